// File: rtl/mpsoc_uart_rx_drain.sv
// UART RX drain engine: per_* bus master that empties the UART RX buffer into a local byte FIFO.
// Optional overflow-drop mode (counter plus clear input) is enabled with `define MPSOC_UART_RX_OVF_DROP_EN.
module mpsoc_uart_rx_drain #(
  parameter int          DEPTH       = 16,
  parameter logic [13:0] RXBUF_ADDR  = 14'h0042,
  parameter logic [13:0] STAT_ADDR   = 14'h0040,
  parameter logic [15:0] RX_IRQ_MASK = 16'h0010
) (
  input  logic                     mclk,
  input  logic                     puc_rst_n,
  output logic                     bus_req,
  input  logic                     bus_gnt,
  output logic [13:0]              per_addr,
  output logic [15:0]              per_din,
  output logic                     per_en,
  output logic [1:0]               per_we,
  input  logic [15:0]              per_dout,
  input  logic                     irq_uart_rx,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
`ifdef MPSOC_UART_RX_OVF_DROP_EN
  output logic [7:0]               ovf_cnt,
  input  logic                     ovf_clr,
`endif
  output logic [$clog2(DEPTH):0]   rx_level
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, REQ, RD, CLR, GAP} state_t;

  state_t      state;
  logic [7:0]  rx_byte;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        full, empty, push_req, push_en, pop_en, accept_ok;
  logic        unused_dout;

  // Only the low byte of the RX buffer register carries data.
  assign unused_dout = ^per_dout[15:8];

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign push_req = (state == CLR);
  assign push_en  = push_req && !full;
  assign pop_en   = rx_ready && !empty;

  assign rx_valid = !empty;
  assign rx_level = wr_ptr - rd_ptr;
  assign rx_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

`ifdef MPSOC_UART_RX_OVF_DROP_EN
  assign accept_ok = 1'b1;

  always_ff @(posedge mclk) begin
    if (!puc_rst_n)                           ovf_cnt <= 8'h00;
    else if (ovf_clr)                         ovf_cnt <= 8'h00;
    else if (push_req && full && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'h01;
  end
`else
  assign accept_ok = !full;
`endif

  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      state    <= IDLE;
      bus_req  <= 1'b0;
      per_en   <= 1'b0;
      per_we   <= 2'b00;
      per_addr <= 14'h0000;
      per_din  <= 16'h0000;
      rx_byte  <= 8'h00;
    end else begin
      // NOTE: strobe fields default to 0 every cycle so they are only non-zero during an access.
      per_en   <= 1'b0;
      per_we   <= 2'b00;
      per_addr <= 14'h0000;
      per_din  <= 16'h0000;
      unique case (state)
        IDLE: if (irq_uart_rx && accept_ok) begin
          state   <= REQ;
          bus_req <= 1'b1;
        end
        REQ: if (bus_gnt) begin
          state    <= RD;
          per_en   <= 1'b1;
          per_addr <= RXBUF_ADDR;
        end
        RD: begin
          rx_byte  <= per_dout[7:0];
          state    <= CLR;
          per_en   <= 1'b1;
          per_we   <= 2'b11;
          per_addr <= STAT_ADDR;
          per_din  <= RX_IRQ_MASK;
        end
        CLR: begin
          state   <= GAP;
          bus_req <= 1'b0;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; rx_data is forced to 0 while empty, so stale entries never show.
  always_ff @(posedge mclk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= rx_byte;
  end

endmodule

// File: tb/tb_mpsoc_uart_rx_drain.sv
// Directed bench for mpsoc_uart_rx_drain; a tiny UART model returns a known byte sequence on each RX read.
// Build with +define+MPSOC_UART_RX_OVF_DROP_EN to also exercise the overflow-drop mode.
module tb_mpsoc_uart_rx_drain;

  logic        mclk = 1'b0;
  logic        puc_rst_n, bus_req, bus_gnt, per_en, irq_uart_rx, rx_valid, rx_ready;
  logic [13:0] per_addr;
  logic [15:0] per_din, per_dout;
  logic [1:0]  per_we;
  logic [7:0]  rx_data;
  logic [4:0]  rx_level;
`ifdef MPSOC_UART_RX_OVF_DROP_EN
  logic [7:0]  ovf_cnt;
  logic        ovf_clr;
`endif

  int          total = 0;
  int          bad   = 0;
  int          rd_cnt = 0;
  int          rd0;
  logic [7:0]  byte_base = 8'h00;
  logic [7:0]  first;

  always #5 mclk = ~mclk;

  mpsoc_uart_rx_drain dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we),
    .per_dout(per_dout), .irq_uart_rx(irq_uart_rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
`ifdef MPSOC_UART_RX_OVF_DROP_EN
    .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr),
`endif
    .rx_level(rx_level)
  );

  // UART model: the n-th RX buffer read returns byte_base + n.
  assign per_dout = (per_en && per_we == 2'b00 && per_addr == 14'h0042)
                    ? {8'h00, byte_base + rd_cnt[7:0]} : 16'h0000;

  always @(posedge mclk) if (per_en && per_we == 2'b00) rd_cnt <= rd_cnt + 1;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_next(input logic [7:0] b);
    byte_base = b - rd_cnt[7:0];
  endtask

  task automatic wait_level(input int target, input int budget);
    for (int i = 0; i < budget && rx_level != target[4:0]; i++) tick();
    check("wait_level", rx_level, target);
  endtask

  initial begin
    puc_rst_n = 1'b0; irq_uart_rx = 1'b1; bus_gnt = 1'b1; rx_ready = 1'b0;
`ifdef MPSOC_UART_RX_OVF_DROP_EN
    ovf_clr = 1'b0;
`endif
    set_next(8'hA5);

    // Reset held with irq asserted: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_bus", {per_we, per_addr, per_din}, 0);
      check("rst_misc", {bus_req, per_en, rx_valid, rx_data, rx_level}, 0);
    end
    puc_rst_n = 1'b1;
    tick();
    check("req_after_rst", {bus_req, per_en}, 2'b10);
    tick();
    check("rd_access", {per_en, per_we, per_addr}, {1'b1, 2'b00, 14'h0042});
    irq_uart_rx = 1'b0;
    tick();
    check("clr_access", {per_en, per_we, per_addr, per_din}, {1'b1, 2'b11, 14'h0040, 16'h0010});
    check("no_valid_in_clr", rx_valid, 1'b0);
    tick();
    check("gap_bus", {bus_req, per_en}, 2'b00);
    check("single_byte", {rx_valid, rx_data, rx_level}, {1'b1, 8'hA5, 5'd1});
    tick();
    check("idle_quiet", bus_req, 1'b0);

    // Grant stall.
    set_next(8'h3C); bus_gnt = 1'b0; irq_uart_rx = 1'b1;
    tick();
    irq_uart_rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall", {bus_req, per_en}, 2'b10);
    end
    bus_gnt = 1'b1;
    tick();
    check("rd_after_gnt", {per_en, per_we, per_addr}, {1'b1, 2'b00, 14'h0042});
    tick(); tick();
    check("stall_level", rx_level, 5'd2);
    tick();
    rx_ready = 1'b1;
    check("head_a5", rx_data, 8'hA5);
    tick();
    check("head_3c", {rx_data, rx_level}, {8'h3C, 5'd1});
    tick();
    check("drained", {rx_valid, rx_level}, 6'd0);
    rx_ready = 1'b0;

    // Fill to DEPTH with 0x00..0x0F.
    set_next(8'h00); irq_uart_rx = 1'b1;
    wait_level(16, 200);
`ifndef MPSOC_UART_RX_OVF_DROP_EN
    rd0 = rd_cnt;
    for (int i = 0; i < 20; i++) tick();
    check("no_rd_when_full", rd_cnt - rd0, 0);
    check("no_req_when_full", bus_req, 1'b0);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("pop_at_full", {rx_level, rx_data}, {5'd15, 8'h01});
    wait_level(16, 40);
    check("refill_head", rx_data, 8'h01);
    irq_uart_rx = 1'b0;
    first = 8'h01;
`else
    irq_uart_rx = 1'b0;
    first = 8'h00;
`endif
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_order", rx_data, first + 8'(i));
      tick();
    end
    check("drain_empty", {rx_valid, rx_level}, 6'd0);
    rx_ready = 1'b0;

    // Simultaneous push and pop at level 5.
    set_next(8'h50); irq_uart_rx = 1'b1;
    wait_level(5, 60);
    irq_uart_rx = 1'b0;
    tick();
    irq_uart_rx = 1'b1;
    tick();
    irq_uart_rx = 1'b0;
    tick(); tick();
    check("in_clr", per_we, 2'b11);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("pushpop_5", {rx_level, rx_data}, {5'd5, 8'h51});
    rx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("order_5", rx_data, 8'h51 + 8'(i));
      tick();
    end
    check("empty_5", rx_valid, 1'b0);
    rx_ready = 1'b0;

`ifdef MPSOC_UART_RX_OVF_DROP_EN
    // Overflow drop: three extra transactions on a full FIFO.
    set_next(8'h20); irq_uart_rx = 1'b1;
    wait_level(16, 200);
    irq_uart_rx = 1'b0;
    tick();
    rd0 = rd_cnt;
    for (int k = 0; k < 3; k++) begin
      irq_uart_rx = 1'b1;
      tick();
      irq_uart_rx = 1'b0;
      for (int i = 0; i < 4; i++) tick();
    end
    check("ovf_rd_count", rd_cnt - rd0, 3);
    check("ovf_cnt", ovf_cnt, 8'd3);
    check("ovf_level", {rx_level, rx_data}, {5'd16, 8'h20});
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", ovf_cnt, 8'd0);
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_order", rx_data, 8'h20 + 8'(i));
      tick();
    end
    rx_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
